// File: rtl/upscaler_pkg.sv
// Shared definitions for the upscaler line scheduler: FSM state encoding,
// a constant-evaluable clog2 and the vertical step code that means unity.
package upscaler_pkg;

  // Scheduler FSM states; the numeric values are also exported as debug state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ARMED = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  // A vertical step code of zero stands for exactly one input line per
  // output line (2^SPH), which cannot otherwise be encoded in SPH bits.
  localparam int ONE_POINT_ZERO = 0;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/upscaler_vstep_accum.sv
// Vertical fixed-point position accumulator. Adds the step on each advance,
// reports the integer carry combinationally, and saturates to all-ones when
// the parent blocks a carrying advance (no line available to move onto).
module upscaler_vstep_accum
  import upscaler_pkg::*;
#(
  parameter int SPH = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [SPH-1:0] step,
  input  logic           advance,
  input  logic           clear,
  input  logic           block,
  output logic [SPH-1:0] frac,
  output logic           carry
);

  localparam logic [SPH-1:0] STEP_UNITY_CODE = ONE_POINT_ZERO[SPH-1:0];

  logic [SPH-1:0] acc_reg;
  logic [SPH:0]   step_ext;
  logic [SPH:0]   sum;

  // Unity is the one step value that needs the extra integer bit.
  assign step_ext = (step == STEP_UNITY_CODE) ? {1'b1, {SPH{1'b0}}} : {1'b0, step};
  assign sum      = {1'b0, acc_reg} + step_ext;
  assign carry    = sum[SPH];
  assign frac     = acc_reg;

  // Accumulator update: clear has priority, a blocked carry pins the
  // fraction just below the next line so the blend stays at the last row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (clear) begin
      acc_reg <= '0;
    end else if (advance) begin
      if (carry && block) begin
        acc_reg <= '1;
      end else begin
        acc_reg <= sum[SPH-1:0];
      end
    end
  end

endmodule

// File: rtl/upscaler_line_scheduler.sv
// Line-buffer ring scheduler for the video upscaler. Tracks the bank being
// written by the input side, the bank pair read by the output side, the
// occupancy level, and flags dropped input lines and refused read advances.
// Everything runs in the output pixel clock domain.
module upscaler_line_scheduler
  import upscaler_pkg::*;
#(
  parameter int LINE_BUFFER_COUNT      = 8,
  parameter int SCALE_PRECISION_HEIGHT = 12,
  parameter int PRIME_LINES            = 2,
  localparam int IDX_W                 = clog2(LINE_BUFFER_COUNT),
  localparam int SPH                   = SCALE_PRECISION_HEIGHT
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_WrFrameStart,
  input  logic             i_WrLineDone,
  input  logic             i_RdFrameStart,
  input  logic             i_RdLineStart,
  input  logic [SPH-1:0]   i_VStep,
  output logic [IDX_W-1:0] o_WrBank,
  output logic [IDX_W-1:0] o_RdBank,
  output logic [IDX_W-1:0] o_RdBankNext,
  output logic [SPH-1:0]   o_VFrac,
  output logic             o_RdValid,
  output logic [IDX_W:0]   o_Level,
  output logic             o_Overrun,
  output logic             o_Underrun,
  output logic [1:0]       o_State
);

  // Level is one bit wider than a bank index so a completely full ring
  // (COUNT lines) is distinguishable from an empty one.
  localparam logic [IDX_W-1:0] BANK_ONE    = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W:0]   LEVEL_ONE   = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [IDX_W:0]   LEVEL_TWO   = {{(IDX_W-1){1'b0}}, 2'b10};
  localparam logic [IDX_W:0]   LEVEL_FULL  = {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W:0]   LEVEL_PRIME = PRIME_LINES[IDX_W:0];

  state_t           state_reg;
  logic [IDX_W-1:0] wr_bank_reg;
  logic [IDX_W-1:0] rd_bank_reg;
  logic [IDX_W-1:0] rd_bank_next_reg;
  logic [IDX_W:0]   level_reg;
  logic             rd_valid_reg;
  logic             overrun_reg;
  logic             underrun_reg;

  logic             frame_restart;
  logic             writer_on;
  logic             rd_advance;
  logic             acc_clear;
  logic             acc_block;
  logic             acc_carry;
  logic             ring_full;
  logic             wr_advance;
  logic             wr_drop;
  logic             rd_release;
  logic             rd_refuse;
  logic [IDX_W:0]   level_next;
  logic [SPH-1:0]   frac;

  // Event decode: which of this cycle's pulses actually take effect.
  always_comb begin
    frame_restart = 1'b0;
    rd_advance    = 1'b0;
    acc_clear     = 1'b0;
    // Input frame start (re)starts filling until reading has begun; once
    // running the ring is continuous and input vsync is ignored.
    if (i_WrFrameStart && (state_reg != ST_RUN)) begin
      frame_restart = 1'b1;
    end
    // A read frame start re-anchors the blend; it wins over a line start.
    if (i_RdFrameStart && ((state_reg == ST_ARMED) || (state_reg == ST_RUN))) begin
      acc_clear = 1'b1;
    end
    if (frame_restart) begin
      acc_clear = 1'b1;
    end
    if ((state_reg == ST_RUN) && i_RdLineStart && !i_RdFrameStart) begin
      rd_advance = 1'b1;
    end
  end

  assign writer_on  = (state_reg != ST_IDLE) && !frame_restart;
  assign ring_full  = (level_reg == LEVEL_FULL);
  assign acc_block  = (level_reg < LEVEL_TWO);
  assign wr_advance = writer_on && i_WrLineDone && !ring_full;
  assign wr_drop    = writer_on && i_WrLineDone && ring_full;
  assign rd_release = rd_advance && acc_carry && !acc_block;
  assign rd_refuse  = rd_advance && acc_carry && acc_block;

  // Occupancy: a write and a release in the same cycle cancel out.
  always_comb begin
    level_next = level_reg;
    if (wr_advance && !rd_release) begin
      level_next = level_reg + LEVEL_ONE;
    end else if (!wr_advance && rd_release) begin
      level_next = level_reg - LEVEL_ONE;
    end
  end

  upscaler_vstep_accum #(
    .SPH (SPH)
  ) u_vstep_accum (
    .clk     (i_Clk),
    .rst_n   (i_Rst_n),
    .step    (i_VStep),
    .advance (rd_advance),
    .clear   (acc_clear),
    .block   (acc_block),
    .frac    (frac),
    .carry   (acc_carry)
  );

  // Scheduler FSM with its registered pointers, level and status pulses.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_reg        <= ST_IDLE;
      wr_bank_reg      <= '0;
      rd_bank_reg      <= '0;
      rd_bank_next_reg <= '0;
      level_reg        <= '0;
      rd_valid_reg     <= 1'b0;
      overrun_reg      <= 1'b0;
      underrun_reg     <= 1'b0;
    end else begin
      overrun_reg  <= wr_drop;
      underrun_reg <= rd_refuse;
      if (frame_restart) begin
        state_reg        <= ST_FILL;
        wr_bank_reg      <= '0;
        rd_bank_reg      <= '0;
        rd_bank_next_reg <= BANK_ONE;
        level_reg        <= '0;
        rd_valid_reg     <= 1'b0;
      end else begin
        if (wr_advance) begin
          wr_bank_reg <= wr_bank_reg + BANK_ONE;
        end
        if (rd_release) begin
          rd_bank_reg      <= rd_bank_next_reg;
          rd_bank_next_reg <= rd_bank_next_reg + BANK_ONE;
        end
        level_reg <= level_next;
        case (state_reg)
          ST_FILL: begin
            if (level_next >= LEVEL_PRIME) begin
              state_reg <= ST_ARMED;
            end
          end
          ST_ARMED: begin
            if (i_RdFrameStart) begin
              state_reg    <= ST_RUN;
              rd_valid_reg <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign o_WrBank     = wr_bank_reg;
  assign o_RdBank     = rd_bank_reg;
  assign o_RdBankNext = rd_bank_next_reg;
  assign o_VFrac      = frac;
  assign o_RdValid    = rd_valid_reg;
  assign o_Level      = level_reg;
  assign o_Overrun    = overrun_reg;
  assign o_Underrun   = underrun_reg;
  assign o_State      = state_reg;

endmodule
